ecg_sample_fetch: RTL and testbench



---
 rtl/ecg_fetch_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/ecg_sample_fetch.sv | 186 ++++++++++++++++++
 tb/tb_ecg_sample_fetch.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecg_fetch_pkg.sv
// ecg_fetch_pkg
//   Shared types and constants for the ECG sample requester.
//   - fetch_state_e : request FSM states
//   - sample_t      : sample word at the default data width
//   - DEF_CLK_DIV   : 100 MHz / 360 Hz sample period in clock cycles
//   - cnt_width()   : counter width able to hold 0..n-1 (at least one bit)
package ecg_fetch_pkg;

    localparam int unsigned DEF_CLK_DIV    = 277778;
    localparam int unsigned DEF_DATA_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock first-word-fall-through FIFO with an occupancy output.
//   Ports:
//     clk, nrst         clock, asynchronous active-low reset
//     i_push, i_data    write strobe and data (ignored when full)
//     o_data, o_valid   head of queue and not-empty flag
//     i_ready           consumer accepts head this cycle
//     o_level           number of entries held
module sync_fifo
    import ecg_fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [LVL_W-1:0]      o_level
);

    localparam int unsigned      PTR_W    = cnt_width(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;

    logic w_do_push;
    logic w_do_pop;

    assign o_valid   = (r_level != '0);
    assign w_do_push = i_push && (r_level != LVL_FULL);
    assign w_do_pop  = o_valid && i_ready;

    // Head is forced to zero while empty so the output is defined from reset.
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Depth is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/ecg_sample_fetch.sv
// ecg_sample_fetch
//   Paces single-sample requests to an ECG source at the record rate, captures
//   the returned sample, checks the source's running sample index and buffers
//   the samples for a valid/ready consumer.
//   Ports:
//     clk, nrst                 clock, asynchronous active-low reset
//     enable                    run the rate divider; low holds it at zero
//     signal_req                one-cycle request pulse to the source
//     signal_valid, signal_in   source response strobe and sample
//     src_counter               source's delivered-sample count incl. current one
//     m_data, m_valid, m_ready  buffered sample stream (first-word fall-through)
//     fifo_level                buffered entries
//     fetched_count             samples captured since reset (wraps)
//     overflow                  sticky: a tick found the buffer full
//     timeout_err               sticky: source did not answer in time
//     seq_err                   sticky: source index disagreed with our count
module ecg_sample_fetch
    import ecg_fetch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned TIMEOUT    = 4,
    parameter int unsigned DATA_WIDTH = 11,
    parameter int unsigned CTR_WIDTH  = 24,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  enable,
    output logic                  signal_req,
    input  logic                  signal_valid,
    input  logic [DATA_WIDTH-1:0] signal_in,
    input  logic [CTR_WIDTH-1:0]  src_counter,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      fifo_level,
    output logic [CTR_WIDTH-1:0]  fetched_count,
    output logic                  overflow,
    output logic                  timeout_err,
    output logic                  seq_err
);

    localparam int unsigned       DIV_W     = cnt_width(CLK_DIV);
    localparam int unsigned       WAIT_W    = cnt_width(TIMEOUT);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    fetch_state_e r_state;
    fetch_state_e w_state_next;

    logic [DIV_W-1:0]     r_div_cnt;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [WAIT_W-1:0]    w_wait_cnt_next;
    logic [CTR_WIDTH-1:0] r_fetched_count;
    logic                 r_overflow;
    logic                 r_timeout_err;
    logic                 r_seq_err;

    logic                 w_tick;
    logic                 w_fifo_full;
    logic                 w_capture;
    logic                 w_set_overflow;
    logic                 w_set_timeout;
    logic [CTR_WIDTH-1:0] w_expected_ctr;
    logic [LVL_W-1:0]     w_fifo_level;

    // ---------------------------------------------------------------- divider
    // Free-running while enabled, so ticks stay periodic regardless of FSM state.
    assign w_tick = enable && (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_div_cnt <= '0;
        end else if (!enable || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------------- FSM
    assign w_fifo_full = (w_fifo_level == LVL_FULL);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_capture       = 1'b0;
        w_set_overflow  = 1'b0;
        w_set_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Space is reserved at tick time; only one request is ever outstanding.
                if (w_tick) begin
                    if (w_fifo_full) begin
                        w_set_overflow = 1'b1;
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ: begin
                w_state_next    = WAIT;
                w_wait_cnt_next = '0;
            end
            WAIT: begin
                if (signal_valid) begin
                    w_capture    = 1'b1;
                    w_state_next = IDLE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_set_timeout = 1'b1;
                    w_state_next  = IDLE;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Decoded straight from the state register, so the pulse is glitch-free.
    assign signal_req = (r_state == REQ);

    // ------------------------------------------------------- capture checks
    // The source counts the sample it is delivering, so it should be one ahead.
    assign w_expected_ctr = r_fetched_count + CTR_WIDTH'(1);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_fetched_count <= '0;
            r_overflow      <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_seq_err       <= 1'b0;
        end else begin
            if (w_set_overflow) begin
                r_overflow <= 1'b1;
            end
            if (w_set_timeout) begin
                r_timeout_err <= 1'b1;
            end
            if (w_capture) begin
                r_fetched_count <= w_expected_ctr;
                if (src_counter != w_expected_ctr) begin
                    r_seq_err <= 1'b1;
                end
            end
        end
    end

    assign fetched_count = r_fetched_count;
    assign overflow      = r_overflow;
    assign timeout_err   = r_timeout_err;
    assign seq_err       = r_seq_err;

    // ----------------------------------------------------------------- buffer
    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .LVL_W      (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .i_push  (w_capture),
        .i_data  (signal_in),
        .o_data  (m_data),
        .o_valid (m_valid),
        .i_ready (m_ready),
        .o_level (w_fifo_level)
    );

    assign fifo_level = w_fifo_level;

endmodule

// File: tb/tb_ecg_sample_fetch.sv
// tb_ecg_sample_fetch
//   Directed sequence with random sample values and a random-ready stretch.
//   The source model answers requests at the falling edge; every delivered
//   sample is queued as the expected output stream, and the head of the DUT
//   buffer is compared with that queue whenever it is valid.
module tb_ecg_sample_fetch;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned TMO     = 4;
    localparam int unsigned DW      = 11;
    localparam int unsigned CW      = 24;
    localparam int unsigned DEPTH   = 8;
    localparam int unsigned LW      = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          enable;
    logic          signal_req;
    logic          signal_valid;
    logic [DW-1:0] signal_in;
    logic [CW-1:0] src_counter;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] fifo_level;
    logic [CW-1:0] fetched_count;
    logic          overflow;
    logic          timeout_err;
    logic          seq_err;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DW-1:0] exp_q [$];
    int            src_cnt;
    int            vcnt;
    bit            withhold;
    bit            skip;
    bit            rand_ready;

    always #5 clk = ~clk;

    ecg_sample_fetch #(
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT    (TMO),
        .DATA_WIDTH (DW),
        .CTR_WIDTH  (CW),
        .FIFO_DEPTH (DEPTH),
        .LVL_W      (LW)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .enable        (enable),
        .signal_req    (signal_req),
        .signal_valid  (signal_valid),
        .signal_in     (signal_in),
        .src_counter   (src_counter),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .fifo_level    (fifo_level),
        .fetched_count (fetched_count),
        .overflow      (overflow),
        .timeout_err   (timeout_err),
        .seq_err       (seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: check the head about to be consumed, advance to the falling
    // edge, then let the source model react to the request line.
    task automatic cycle();
        if (m_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("head_unexpected", 32'(m_valid), 32'd0);
            end else begin
                chk("head_data", 32'(m_data), 32'(exp_q[0]));
                if (m_ready) void'(exp_q.pop_front());
            end
        end
        @(negedge clk);
        cyc++;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        if (nrst && signal_req === 1'b1) begin
            if (withhold) begin
                withhold = 1'b0;
            end else begin
                src_cnt     += skip ? 2 : 1;
                skip         = 1'b0;
                signal_in    = DW'($urandom_range(0, 2047));
                src_counter  = CW'(src_cnt);
                signal_valid = 1'b1;
                vcnt         = 2;
                exp_q.push_back(signal_in);
            end
        end else if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0) signal_valid = 1'b0;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) cycle();
    endtask

    task automatic wait_req(output int r);
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (signal_req === 1'b1) begin
                r = cyc;
                return;
            end
        end
        chk("req_wait_expired", 32'(signal_req), 32'd1);
        r = cyc;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_signal_req"}, 32'(signal_req), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
        chk({tag, "_fetched_count"}, 32'(fetched_count), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    endtask

    initial begin
        int p;
        int r;
        int prev;
        int cnt;

        nrst = 1'b0; enable = 1'b0; m_ready = 1'b1;
        signal_valid = 1'b0; signal_in = '0; src_counter = '0;
        src_cnt = 0; vcnt = 0; withhold = 1'b0; skip = 1'b0; rand_ready = 1'b0;
        repeat (3) cycle();
        check_reset_values("reset");
        nrst = 1'b1;
        repeat (2) cycle();

        // Nominal pacing, then a random-ready stretch.
        enable = 1'b1;
        p = cyc;
        wait_req(r);
        chk("first_req_latency", 32'(r - p), 32'(CLK_DIV));
        run_to(r + 2);
        chk("first_sample_valid", 32'(m_valid), 32'd1);
        chk("first_sample_level", 32'(fifo_level), 32'd1);
        prev = r;
        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_req(r);
            chk("req_period", 32'(r - prev), 32'(CLK_DIV));
            prev = r;
        end
        rand_ready = 1'b0;
        m_ready = 1'b1;
        wait_req(r);
        chk("req_period", 32'(r - prev), 32'(CLK_DIV));
        run_to(r + 3);
        chk("nominal_level", 32'(fifo_level), 32'd0);
        chk("nominal_fetched", 32'(fetched_count), 32'd5);
        chk("nominal_overflow", 32'(overflow), 32'd0);
        chk("nominal_timeout", 32'(timeout_err), 32'd0);
        chk("nominal_seq", 32'(seq_err), 32'd0);

        // Back-pressure: 8 requests fill the buffer, ticks 9 and 10 are skipped.
        m_ready = 1'b0;
        prev = r;
        for (int i = 0; i < 8; i++) begin
            wait_req(r);
            chk("fill_req_period", 32'(r - prev), 32'(CLK_DIV));
            prev = r;
        end
        run_to(prev + 15);
        chk("overflow_before_tick9", 32'(overflow), 32'd0);
        cycle();
        chk("overflow_at_tick9", 32'(overflow), 32'd1);
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        cnt = 0;
        while (cyc < prev + 40) begin
            cycle();
            if (signal_req === 1'b1) cnt++;
        end
        chk("no_req_while_full", 32'(cnt), 32'd0);
        chk("full_fetched", 32'(fetched_count), 32'd13);

        // Drain in order; the next request goes unanswered.
        m_ready = 1'b1;
        withhold = 1'b1;
        wait_req(r);
        chk("req_after_drain", 32'(r - prev), 32'(3 * CLK_DIV));
        chk("drained_level", 32'(fifo_level), 32'd0);
        chk("drained_all", 32'(exp_q.size()), 32'd0);
        prev = r;
        run_to(r + TMO);
        chk("timeout_not_yet", 32'(timeout_err), 32'd0);
        cycle();
        chk("timeout_set", 32'(timeout_err), 32'd1);
        chk("timeout_fetched", 32'(fetched_count), 32'd13);
        wait_req(r);
        chk("req_after_timeout", 32'(r - prev), 32'(CLK_DIV));
        run_to(r + 2);
        chk("recover_fetched", 32'(fetched_count), 32'd14);
        chk("recover_valid", 32'(m_valid), 32'd1);
        chk("recover_seq", 32'(seq_err), 32'd0);

        // Source skips an index.
        skip = 1'b1;
        prev = r;
        wait_req(r);
        chk("skip_req_period", 32'(r - prev), 32'(CLK_DIV));
        run_to(r + 2);
        chk("skip_seq_err", 32'(seq_err), 32'd1);
        chk("skip_fetched", 32'(fetched_count), 32'd15);
        chk("skip_sample_pushed", 32'(m_valid), 32'd1);
        cycle();

        // Reset while waiting with three entries held.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) wait_req(r);
        withhold = 1'b1;
        wait_req(r);
        run_to(r + 2);
        chk("held_level", 32'(fifo_level), 32'd3);
        nrst = 1'b0;
        #1;
        check_reset_values("midwait_reset");
        exp_q.delete();
        src_cnt = 0; vcnt = 0; signal_valid = 1'b0; withhold = 1'b0; skip = 1'b0;
        m_ready = 1'b1;
        repeat (2) cycle();
        nrst = 1'b1;
        p = cyc;
        wait_req(r);
        chk("req_after_reset", 32'(r - p), 32'(CLK_DIV));
        run_to(r + 3);
        chk("post_reset_fetched", 32'(fetched_count), 32'd1);
        chk("post_reset_seq", 32'(seq_err), 32'd0);

        // Enable low for five cycles restarts the divider.
        enable = 1'b0;
        cnt = 0;
        repeat (5) begin
            cycle();
            if (signal_req === 1'b1) cnt++;
        end
        chk("no_req_disabled", 32'(cnt), 32'd0);
        enable = 1'b1;
        p = cyc;
        wait_req(r);
        chk("req_after_enable", 32'(r - p), 32'(CLK_DIV));
        run_to(r + 2);
        chk("final_fetched", 32'(fetched_count), 32'd2);
        chk("final_valid", 32'(m_valid), 32'd1);
        chk("final_seq", 32'(seq_err), 32'd0);
        chk("final_timeout", 32'(timeout_err), 32'd0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
